// File: rtl/kp_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
//  kp_state_t : scanner FSM states
//  KPC_RESET  : column drive after reset (column 0 selected)
//  KP_IDLE    : row sense value with no key pressed
//  kp_code    : maps {column drive, row sense} to the team key code
//  one_low    : 1 when exactly one bit of a 4-bit vector is 0
//  kpc_next   : next column drive in the rotation 0111->1011->1101->1110
package kp_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  localparam logic [3:0] KPC_RESET = 4'b0111;
  localparam logic [3:0] KP_IDLE   = 4'hF;

  function automatic logic [3:0] kp_code(input logic [3:0] kpc, input logic [3:0] kpr);
    logic [1:0] w_col;
    logic [1:0] w_row;
    logic [3:0] w_code;
    w_col = 2'd0;
    w_row = 2'd0;
    case (kpc)
      4'b0111: w_col = 2'd0;
      4'b1011: w_col = 2'd1;
      4'b1101: w_col = 2'd2;
      4'b1110: w_col = 2'd3;
      default: w_col = 2'd0;
    endcase
    case (kpr)
      4'b0111: w_row = 2'd0;
      4'b1011: w_row = 2'd1;
      4'b1101: w_row = 2'd2;
      4'b1110: w_row = 2'd3;
      default: w_row = 2'd0;
    endcase
    case ({w_row, w_col})
      4'h0: w_code = 4'h1;
      4'h1: w_code = 4'h2;
      4'h2: w_code = 4'h3;
      4'h3: w_code = 4'hA;
      4'h4: w_code = 4'h4;
      4'h5: w_code = 4'h5;
      4'h6: w_code = 4'h6;
      4'h7: w_code = 4'hB;
      4'h8: w_code = 4'h7;
      4'h9: w_code = 4'h8;
      4'hA: w_code = 4'h9;
      4'hB: w_code = 4'hC;
      4'hC: w_code = 4'hE;
      4'hD: w_code = 4'h0;
      4'hE: w_code = 4'hF;
      default: w_code = 4'hD;
    endcase
    return w_code;
  endfunction

  function automatic logic one_low(input logic [3:0] v);
    logic w_res;
    case (v)
      4'b0111, 4'b1011, 4'b1101, 4'b1110: w_res = 1'b1;
      default:                            w_res = 1'b0;
    endcase
    return w_res;
  endfunction

  // Rotate right; an illegal drive pattern recovers to column 0.
  function automatic logic [3:0] kpc_next(input logic [3:0] kpc);
    logic [3:0] w_next;
    if (one_low(kpc)) begin
      w_next = {kpc[0], kpc[3:1]};
    end else begin
      w_next = KPC_RESET;
    end
    return w_next;
  endfunction

endpackage

// File: rtl/kp_scanner_if.sv
// Keypad pin and key event bundle.
//  kpr       : row sense, active-low (from keypad pins)
//  kpc       : column drive, one bit low (to keypad pins)
//  key_valid : one-clk pulse per accepted key
//  key_code  : code of the last accepted key
//  key_held  : accepted key still pressed
// master = scanner side, slave = keypad/consumer side.
interface kp_scanner_if;
  logic [3:0] kpr;
  logic [3:0] kpc;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  modport master (
    input  kpr,
    output kpc,
    output key_valid,
    output key_code,
    output key_held
  );

  modport slave (
    output kpr,
    input  kpc,
    input  key_valid,
    input  key_code,
    input  key_held
  );
endinterface

// File: rtl/kp_tick.sv
// Scan prescaler: free-running counter 0..DIV-1, o_tick high for one clk at DIV-1.
//  i_clk   : system clock
//  i_reset : synchronous active-high reset (counter to 0)
//  o_tick  : scan tick pulse
module kp_tick #(
  parameter int unsigned DIV = 50_000
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;
  logic         w_tick;

  assign w_tick = (r_cnt == LAST);
  assign o_tick = w_tick;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/kp_scanner.sv
// 4x4 keypad scanner: drives one-hot-low columns, synchronises the rows, debounces press and
// release, and emits one registered key event per physical press.
//  clk   : system clock
//  reset : synchronous active-high reset
//  kp    : keypad pins (kpr in, kpc out) and key event outputs (key_valid/key_code/key_held)
module kp_scanner
  import kp_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50_000,
  parameter int unsigned DEBOUNCE_CNT = 20
) (
  input  logic            clk,
  input  logic            reset,
  kp_scanner_if.master    kp
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CNT);

  logic          w_tick;
  logic [3:0]    r_sync1;
  logic [3:0]    r_kpr_s;

  kp_state_t     r_state, w_state_d;
  logic [3:0]    r_kpc, w_kpc_d;
  logic [7:0]    r_cand, w_cand_d;   // {kpc, row} of the key being debounced
  logic [DW-1:0] r_deb, w_deb_d;
  logic [DW-1:0] w_deb_inc;
  logic [3:0]    r_key_code, w_key_code_d;
  logic          r_key_valid, w_key_valid_d;
  logic          r_key_held, w_key_held_d;

  kp_tick #(
    .DIV (SCAN_DIV)
  ) u_tick (
    .i_clk   (clk),
    .i_reset (reset),
    .o_tick  (w_tick)
  );

  // kpr is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= KP_IDLE;
      r_kpr_s <= KP_IDLE;
    end else begin
      r_sync1 <= kp.kpr;
      r_kpr_s <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= SCAN;
      r_kpc       <= KPC_RESET;
      r_cand      <= 8'hFF;
      r_deb       <= '0;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_kpc       <= w_kpc_d;
      r_cand      <= w_cand_d;
      r_deb       <= w_deb_d;
      r_key_code  <= w_key_code_d;
      r_key_valid <= w_key_valid_d;
      r_key_held  <= w_key_held_d;
    end
  end

  assign w_deb_inc = r_deb + 1'b1;

  always_comb begin
    w_state_d     = r_state;
    w_kpc_d       = r_kpc;
    w_cand_d      = r_cand;
    w_deb_d       = r_deb;
    w_key_code_d  = r_key_code;
    w_key_valid_d = 1'b0;
    if (w_tick) begin
      unique case (r_state)
        SCAN: begin
          // Multi-zero rows are ghosting or multi-key presses; skip them.
          if (one_low(r_kpr_s)) begin
            w_cand_d  = {r_kpc, r_kpr_s};
            w_deb_d   = '0;
            w_state_d = DEBOUNCE;
          end else begin
            w_kpc_d = kpc_next(r_kpc);
          end
        end
        DEBOUNCE: begin
          if (r_kpr_s == r_cand[3:0]) begin
            if (w_deb_inc == DEB_LAST) begin
              w_state_d     = PRESSED;
              w_key_code_d  = kp_code(r_cand[7:4], r_cand[3:0]);
              w_key_valid_d = 1'b1;
            end else begin
              w_deb_d = w_deb_inc;
            end
          end else begin
            w_state_d = SCAN;
            w_kpc_d   = kpc_next(r_kpc);
          end
        end
        PRESSED: begin
          if (r_kpr_s == KP_IDLE) begin
            w_deb_d   = '0;
            w_state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (r_kpr_s == KP_IDLE) begin
            if (w_deb_inc == DEB_LAST) begin
              w_state_d = SCAN;
              w_kpc_d   = kpc_next(r_kpc);
            end else begin
              w_deb_d = w_deb_inc;
            end
          end else begin
            // Bounce during release: keep the key held, no new event.
            w_state_d = PRESSED;
          end
        end
        default: begin
          w_state_d = SCAN;
        end
      endcase
    end
    w_key_held_d = (w_state_d == PRESSED) || (w_state_d == RELEASE);
  end

  assign kp.kpc       = r_kpc;
  assign kp.key_valid = r_key_valid;
  assign kp.key_code  = r_key_code;
  assign kp.key_held  = r_key_held;

endmodule

// File: tb/tb_kp_scanner.sv
module tb_kp_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  kp_scanner_if kp ();

  kp_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  bit cmp_en  = 1'b0;

  // Keypad model: the pressed switch pulls its row(s) low while its column is driven low.
  int         press_col = -1;
  logic [3:0] press_row = 4'hF;

  function automatic logic [3:0] colmask(input int c);
    logic [3:0] m;
    m = 4'b1000 >> c;
    return ~m;
  endfunction

  assign kp.kpr = (press_col >= 0 && kp.kpc == colmask(press_col)) ? press_row : 4'hF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, tick-level view of the keypad behaviour.
  logic [3:0] keymap [0:3][0:3] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                    '{4'h4, 4'h5, 4'h6, 4'hB},
                                    '{4'h7, 4'h8, 4'h9, 4'hC},
                                    '{4'hE, 4'h0, 4'hF, 4'hD}};

  function automatic int row_of(input logic [3:0] v);
    for (int r = 0; r < 4; r++) if (v[3-r] == 1'b0) return r;
    return 0;
  endfunction

  int         m_cyc, m_phase, m_col, m_deb, m_cand_col;
  logic [3:0] m_cand_row, m_s1, m_s2, m_code;
  bit         m_valid, m_held;

  always @(posedge clk) begin
    logic [3:0] s;
    bit tick;
    if (reset) begin
      m_cyc = 0; m_phase = 0; m_col = 0; m_deb = 0; m_cand_col = 0;
      m_cand_row = 4'hF; m_s1 = 4'hF; m_s2 = 4'hF; m_code = 4'h0;
      m_valid = 1'b0; m_held = 1'b0;
    end else begin
      s = m_s2;
      m_s2 = m_s1;
      m_s1 = kp.kpr;
      tick = (m_cyc == SCAN_DIV - 1);
      m_cyc = (m_cyc + 1) % SCAN_DIV;
      m_valid = 1'b0;
      if (tick) begin
        case (m_phase)
          0: if ($countones(~s) == 1) begin
               m_cand_row = s; m_cand_col = m_col; m_deb = 0; m_phase = 1;
             end else m_col = (m_col + 1) % 4;
          1: if (s == m_cand_row) begin
               m_deb++;
               if (m_deb == DEB) begin
                 m_phase = 2; m_valid = 1'b1;
                 m_code = keymap[row_of(s)][m_cand_col];
               end
             end else begin
               m_phase = 0; m_col = (m_col + 1) % 4;
             end
          2: if (s == 4'hF) begin m_deb = 0; m_phase = 3; end
          default: if (s == 4'hF) begin
               m_deb++;
               if (m_deb == DEB) begin m_phase = 0; m_col = (m_col + 1) % 4; end
             end else m_phase = 2;
        endcase
      end
      m_held = (m_phase >= 2);
    end
  end

  always @(negedge clk) begin
    if (kp.key_valid === 1'b1) n_valid++;
    if (cmp_en) begin
      check("model kpc", 32'(kp.kpc), 32'(colmask(m_col)));
      check("model key_valid", 32'(kp.key_valid), 32'(m_valid));
      check("model key_code", 32'(kp.key_code), 32'(m_code));
      check("model key_held", 32'(kp.key_held), 32'(m_held));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (kp.key_valid !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(k < 200), 32'd1);
  endtask

  task automatic wait_released(input string name);
    int k = 0;
    while (kp.key_held !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(k < 200), 32'd1);
  endtask

  initial begin
    logic [3:0] seq [0:3];
    logic [3:0] prev;
    int n0, k, changes;
    seq[0] = 4'b1011; seq[1] = 4'b1101; seq[2] = 4'b1110; seq[3] = 4'b0111;

    // 1: reset and idle scan
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    cmp_en = 1'b1;
    check("t1 reset kpc", 32'(kp.kpc), 32'h7);
    check("t1 reset key_valid", 32'(kp.key_valid), 32'd0);
    check("t1 reset key_code", 32'(kp.key_code), 32'd0);
    check("t1 reset key_held", 32'(kp.key_held), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(4);
      check("t1 kpc rotation", 32'(kp.kpc), 32'(seq[i]));
    end

    // 2: press and hold '5'
    n0 = n_valid;
    press_col = 1; press_row = 4'b1011;
    wait_valid("t2 key_valid timeout");
    check("t2 key_code", 32'(kp.key_code), 32'h5);
    check("t2 key_held", 32'(kp.key_held), 32'd1);
    check("t2 kpc frozen", 32'(kp.kpc), 32'hB);
    step(40);
    check("t2 kpc still frozen", 32'(kp.kpc), 32'hB);
    check("t2 held while pressed", 32'(kp.key_held), 32'd1);
    check("t2 one pulse", 32'(n_valid - n0), 32'd1);
    press_col = -1;
    wait_released("t2 release timeout");

    // 3: one-tick glitch on '5'
    n0 = n_valid;
    prev = kp.kpc;
    k = 0;
    while (!(kp.kpc == 4'b1011 && prev != 4'b1011) && k < 100) begin
      prev = kp.kpc;
      @(negedge clk);
      k++;
    end
    check("t3 align timeout", 32'(k < 100), 32'd1);
    press_col = 1; press_row = 4'b1011;
    step(4);
    check("t3 kpc frozen on detect", 32'(kp.kpc), 32'hB);
    press_col = -1;
    step(4);
    check("t3 scan resumes", 32'(kp.kpc), 32'hD);
    step(20);
    check("t3 no event", 32'(n_valid - n0), 32'd0);

    // 4: hold 'D', bounce once during release
    n0 = n_valid;
    press_col = 3; press_row = 4'b1110;
    wait_valid("t4 key_valid timeout");
    check("t4 key_code", 32'(kp.key_code), 32'hD);
    press_col = -1;
    step(4);
    press_col = 3;
    step(4);
    press_col = -1;
    step(15);
    check("t4 held before idle run ends", 32'(kp.key_held), 32'd1);
    step(1);
    check("t4 held falls", 32'(kp.key_held), 32'd0);
    check("t4 kpc after release", 32'(kp.kpc), 32'h7);
    check("t4 one pulse", 32'(n_valid - n0), 32'd1);

    // 5: two rows low in one column
    n0 = n_valid;
    press_col = 0; press_row = 4'b0011;
    changes = 0;
    for (int i = 0; i < 32; i++) begin
      prev = kp.kpc;
      step(1);
      if (kp.kpc != prev) changes++;
    end
    check("t5 kpc keeps rotating", 32'(changes), 32'd8);
    check("t5 no event", 32'(n_valid - n0), 32'd0);
    press_col = -1;
    step(8);

    // 6: reset while '1' is held
    n0 = n_valid;
    press_col = 0; press_row = 4'b0111;
    wait_valid("t6 first key_valid timeout");
    check("t6 first key_code", 32'(kp.key_code), 32'h1);
    step(6);
    reset = 1'b1;
    step(1);
    check("t6 reset kpc", 32'(kp.kpc), 32'h7);
    check("t6 reset key_valid", 32'(kp.key_valid), 32'd0);
    check("t6 reset key_code", 32'(kp.key_code), 32'd0);
    check("t6 reset key_held", 32'(kp.key_held), 32'd0);
    reset = 1'b0;
    wait_valid("t6 second key_valid timeout");
    check("t6 second key_code", 32'(kp.key_code), 32'h1);
    step(2);
    check("t6 two pulses", 32'(n_valid - n0), 32'd2);
    press_col = -1;
    wait_released("t6 release timeout");
    step(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
